uart_tx_queue: RTL and testbench

//  Byte FIFO and transmit sequencer that sits directly upstream of the uart transmitter.
//  The bus side pushes bytes with a single-cycle strobe. The block drains them one at a time

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_queue_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_queue.sv | 102 ++++++++++
 tb/tb_uart_tx_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit path: byte width and queue sequencer states.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// sync_fifo: single-clock byte queue with registered occupancy flags and a
// combinational head output. Storage is not reset; pointers and flags are.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Qualify against the registered flags so a write while full is dropped
  // even when a pop happens on the same edge.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + (ADDR_WIDTH+1)'(1);
      2'b01:   count_nxt = count - (ADDR_WIDTH+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus IDLE/SEND/BUSY sequencer feeding the uart transmitter.
// Optional UART_TXQ_OVF_CNT_EN adds a saturating dropped-write counter port ovf_count.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_WIDTH-1:0]    uart_data,
  output logic                     uart_en,
  input  logic                     uart_busy
`ifdef UART_TXQ_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_count
`endif
);

  txq_state_t            state;
  txq_state_t            state_nxt;
  logic                  pop;
  logic                  load;
  logic                  en_nxt;
  logic [DATA_WIDTH-1:0] head;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // SEND only advances once the uart has seen data_en; a busy level that was
  // already present before uart_en rose is not taken as acceptance.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    en_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (uart_en && uart_busy) begin
          pop       = 1'b1;
          state_nxt = BUSY;
        end else begin
          en_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (!uart_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      uart_en   <= 1'b0;
      uart_data <= '0;
    end else begin
      state   <= state_nxt;
      uart_en <= en_nxt;
      if (load) uart_data <= head;
    end
  end

`ifdef UART_TXQ_OVF_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_count <= 8'd0;
    end else if (wr_en && full) begin
      ovf_count <= sat_inc8(ovf_count);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural uart stand-in that captures bytes.
module tb_uart_tx_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int FRAME = 160;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic [DW-1:0] uart_data;
  logic          uart_en;
  logic          uart_busy;
`ifdef UART_TXQ_OVF_CNT_EN
  logic [7:0]    ovf_count;
`endif

  logic          model_on;
  logic          model_busy;
  logic          force_busy;
  int            model_cnt;
  logic [DW-1:0] rx_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign uart_busy = model_on ? model_busy : force_busy;

  uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .uart_data (uart_data),
    .uart_en   (uart_en),
    .uart_busy (uart_busy)
`ifdef UART_TXQ_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  // uart stand-in: latch byte on data_en, stay busy for one 10-bit frame
  always @(posedge clk) begin
    if (!model_on) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_busy) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_busy <= 1'b0;
    end else if (uart_en) begin
      rx_q.push_back(uart_data);
      model_busy <= 1'b1;
      model_cnt  <= FRAME;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 4000; i++) begin
      if (rx_q.size() >= n && !uart_busy) break;
      step();
    end
    chk("rx_cnt", rx_q.size(), n);
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    wr_data    = '0;
    wr_en      = 1'b0;
    model_on   = 1'b0;
    force_busy = 1'b0;
    model_busy = 1'b0;
    model_cnt  = 0;
    step();
    step();
    rstn = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_en", uart_en, 0);
    chk("rst_data", uart_data, 0);
`ifdef UART_TXQ_OVF_CNT_EN
    chk("rst_ovf", ovf_count, 0);
`endif

    // Single byte: uart_en two edges after the write, then popped
    model_on = 1'b1;
    push(8'hA5);
    chk("t1_empty", empty, 0);
    chk("t1_count", count, 1);
    chk("t1_en_n0", uart_en, 0);
    step();
    chk("t1_en_n1", uart_en, 0);
    step();
    chk("t1_en_n2", uart_en, 1);
    chk("t1_data", uart_data, 8'hA5);
    step();
    step();
    chk("t1_en_pop", uart_en, 0);
    chk("t1_empty_pop", empty, 1);
    wait_rx(1);
    if (rx_q.size() >= 1) chk("t1_rx", rx_q[0], 8'hA5);
    repeat (3) step();

    // Back-to-back burst drained in order
    rx_q.delete();
    for (int i = 1; i <= 4; i++) begin
      wr_data = DW'(i);
      wr_en   = 1'b1;
      step();
    end
    wr_en = 1'b0;
    chk("t2_count4", count, 4);
    wait_rx(4);
    for (int i = 0; i < 4; i++)
      if (rx_q.size() > i) chk("t2_rx", rx_q[i], DW'(i + 1));
    repeat (3) step();
    chk("t2_count0", count, 0);
    chk("t2_empty", empty, 1);

    // Overfill with uart stalled: 17th byte dropped
    model_on   = 1'b0;
    force_busy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_data = DW'(8'h10 + i);
      wr_en   = 1'b1;
      step();
      if (i == 15) begin
        chk("t3_full16", full, 1);
        chk("t3_count16", count, 16);
      end
    end
    wr_en = 1'b0;
    chk("t3_full17", full, 1);
    chk("t3_count17", count, 16);
`ifdef UART_TXQ_OVF_CNT_EN
    chk("t3_ovf", ovf_count, 1);
`endif

    // uart never goes busy: SEND holds
    repeat (20) step();
    chk("t6_en", uart_en, 1);
    chk("t6_data", uart_data, 8'h10);
    chk("t6_count", count, 16);

    // Full + pop + write in the same cycle: write dropped
    force_busy = 1'b1;
    wr_data    = 8'h55;
    wr_en      = 1'b1;
    step();
    wr_en = 1'b0;
    chk("t4_count", count, 15);
    chk("t4_full", full, 0);
    chk("t4_en", uart_en, 0);
`ifdef UART_TXQ_OVF_CNT_EN
    chk("t4_ovf", ovf_count, 2);
`endif
    force_busy = 1'b0;
    step();
    step();
    chk("t4_next_head", uart_data, 8'h11);

    // Reset while in BUSY with 3 bytes queued
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(8'h31 + i));
    chk("t5_en_send", uart_en, 1);
    force_busy = 1'b1;
    step();
    chk("t5_count3", count, 3);
    chk("t5_en_busy", uart_en, 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("t5_en", uart_en, 0);
    chk("t5_empty", empty, 1);
    chk("t5_count", count, 0);
    chk("t5_full", full, 0);
    chk("t5_data", uart_data, 0);

    // uart busy from elsewhere while IDLE: SEND still raises uart_en
    push(8'h77);
    step();
    step();
    chk("t7_en", uart_en, 1);
    chk("t7_data", uart_data, 8'h77);
    chk("t7_count", count, 1);
    step();
    chk("t7_pop", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
